// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one downstream memory/IO port between the execute unit (master 0)
//   and a DMA/debug master (master 1).  Each transaction is sequenced
//   IDLE -> BUSY -> DONE.  When both masters are pending in IDLE, the master
//   that did not win last time gets the bus.  A watchdog aborts a BUSY phase
//   that has waited TIMEOUT cycles without m_ready.
//
// Handshakes:
//   core : level-held request (c_ifetch / c_rstrobe / c_wmask).  One
//          c_idone/c_rdone/c_wdone pulse ends it.  Read data is on c_rdata
//          with that pulse.
//   dma  : d_req held until the one-cycle d_ack.  Read data is on d_rdata
//          with d_ack.
//   bus  : m_valid and the m_* fields are held stable until completion.
//          m_ready completes the transfer.  m_rdata is sampled in the same
//          cycle as m_ready.
//   bus_fault pulses together with the done pulse of a watchdog-aborted
//          transfer.  Read data for that transfer is all ones.
//
// Ports:
//   clk, reset                      clock, synchronous active-low reset
//   c_ifetch, c_rstrobe, c_wmask    core request (write > read > fetch)
//   c_addr, c_wdata, c_io           core address / write data / IO space
//   c_idone, c_rdone, c_wdone       core completion pulses
//   c_rdata                         core read data
//   d_req, d_we, d_addr, d_wmask,   DMA request
//   d_wdata
//   d_ack, d_rdata                  DMA completion pulse / read data
//   m_valid, m_we, m_addr, m_wmask, downstream request
//   m_rstrobe, m_wdata, m_io
//   m_ready, m_rdata                downstream completion / read data
//   bus_fault                       watchdog abort pulse
module mem_bus_arbiter #(
   parameter int RV      = 32,
   parameter int VA      = RV,
   parameter int AW      = VA - RV/16,
   parameter int TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            c_ifetch,
   input  logic [1:0]      c_rstrobe,
   input  logic [RV/8-1:0] c_wmask,
   input  logic [AW-1:0]   c_addr,
   input  logic [RV-1:0]   c_wdata,
   input  logic            c_io,
   output logic            c_idone,
   output logic            c_rdone,
   output logic            c_wdone,
   output logic [RV-1:0]   c_rdata,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [AW-1:0]   d_addr,
   input  logic [RV/8-1:0] d_wmask,
   input  logic [RV-1:0]   d_wdata,
   output logic            d_ack,
   output logic [RV-1:0]   d_rdata,
   output logic            m_valid,
   output logic            m_we,
   output logic [AW-1:0]   m_addr,
   output logic [RV/8-1:0] m_wmask,
   output logic [1:0]      m_rstrobe,
   output logic [RV-1:0]   m_wdata,
   output logic            m_io,
   input  logic            m_ready,
   input  logic [RV-1:0]   m_rdata,
   output logic            bus_fault
);

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

   localparam logic [1:0] K_FETCH = 2'd0;
   localparam logic [1:0] K_READ  = 2'd1;
   localparam logic [1:0] K_WRITE = 2'd2;
   localparam logic [7:0] COUNT_LAST = 8'(TIMEOUT - 1);

   state_t        state, state_nx;
   logic          last_grant;   // 1 = DMA had the bus last
   logic          grant;        // owner of the current transfer, 1 = DMA
   logic [1:0]    kind;         // core transfer type
   logic [7:0]    count;        // BUSY cycles elapsed
   logic          creq, pick_dma, finish, timed_out;
   logic          start, complete, retire, counting;
   logic [RV-1:0] rd_word;

   assign creq = c_ifetch | (|c_rstrobe) | (|c_wmask);
   // The DMA wins when it is alone.  On a tie it wins when the core had the bus last.
   assign pick_dma  = d_req & (~creq | ~last_grant);
   assign finish    = m_ready | (count == COUNT_LAST);
   assign timed_out = ~m_ready;
   assign rd_word   = m_ready ? m_rdata : {RV{1'b1}};

   // State register
   always_ff @(posedge clk) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nx;
   end

   // Next-state logic.  DONE never looks at requests.  A master still holding
   // its request during its done cycle is therefore not served twice.
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (creq | d_req) state_nx = ST_BUSY;
         ST_BUSY: if (finish)       state_nx = ST_DONE;
         ST_DONE:                   state_nx = ST_IDLE;
         default:                   state_nx = ST_IDLE;
      endcase
   end

   // Output/control decode
   always_comb begin
      start    = 1'b0;
      complete = 1'b0;
      retire   = 1'b0;
      counting = 1'b0;
      case (state)
         ST_IDLE: start = creq | d_req;
         ST_BUSY: begin
            complete = finish;
            counting = ~finish;
         end
         ST_DONE: retire = 1'b1;
         default: ;
      endcase
   end

   // Registered datapath and output pulses
   always_ff @(posedge clk) begin
      if (!reset) begin
         last_grant <= 1'b1;
         grant      <= 1'b0;
         kind       <= K_FETCH;
         count      <= 8'd0;
         m_valid    <= 1'b0;
         m_we       <= 1'b0;
         m_wmask    <= '0;
         m_rstrobe  <= 2'b00;
         m_io       <= 1'b0;
         m_addr     <= '0;
         m_wdata    <= '0;
         c_idone    <= 1'b0;
         c_rdone    <= 1'b0;
         c_wdone    <= 1'b0;
         d_ack      <= 1'b0;
         bus_fault  <= 1'b0;
         c_rdata    <= '0;
         d_rdata    <= '0;
      end else begin
         c_idone   <= 1'b0;
         c_rdone   <= 1'b0;
         c_wdone   <= 1'b0;
         d_ack     <= 1'b0;
         bus_fault <= 1'b0;

         if (start) begin
            count   <= 8'd0;
            m_valid <= 1'b1;
            grant   <= pick_dma;
            if (pick_dma) begin
               m_we      <= d_we;
               m_addr    <= d_addr;
               m_wdata   <= d_wdata;
               m_io      <= 1'b0;
               m_wmask   <= d_we ? d_wmask : '0;
               m_rstrobe <= d_we ? 2'b00 : 2'b11;
            end else begin
               m_addr  <= c_addr;
               m_wdata <= c_wdata;
               if (|c_wmask) begin
                  kind      <= K_WRITE;
                  m_we      <= 1'b1;
                  m_wmask   <= c_wmask;
                  m_rstrobe <= 2'b00;
                  m_io      <= c_io;
               end else if (|c_rstrobe) begin
                  kind      <= K_READ;
                  m_we      <= 1'b0;
                  m_wmask   <= '0;
                  m_rstrobe <= c_rstrobe;
                  m_io      <= c_io;
               end else begin
                  kind      <= K_FETCH;
                  m_we      <= 1'b0;
                  m_wmask   <= '0;
                  m_rstrobe <= 2'b11;
                  m_io      <= 1'b0;
               end
            end
         end

         if (counting) count <= count + 8'd1;

         if (complete) begin
            m_valid   <= 1'b0;
            bus_fault <= timed_out;
            if (grant) begin
               d_ack <= 1'b1;
               if (!m_we) d_rdata <= rd_word;
            end else begin
               case (kind)
                  K_WRITE: c_wdone <= 1'b1;
                  K_READ: begin
                     c_rdone <= 1'b1;
                     c_rdata <= rd_word;
                  end
                  default: begin
                     c_idone <= 1'b1;
                     c_rdata <= rd_word;
                  end
               endcase
            end
         end

         if (retire) last_grant <= grant;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter (RV=32, TIMEOUT=4).
// Directed scenarios with literal expectations are followed by a randomized
// two-master phase.  A transaction-level reference model predicts every
// output in every cycle.
module tb_mem_bus_arbiter;

   localparam int RV      = 32;
   localparam int AW      = 30;
   localparam int MW      = RV/8;
   localparam int TIMEOUT = 4;
   localparam int K_FETCH = 0, K_READ = 1, K_WRITE = 2, K_DMA = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic          c_ifetch;
   logic [1:0]    c_rstrobe;
   logic [MW-1:0] c_wmask;
   logic [AW-1:0] c_addr;
   logic [RV-1:0] c_wdata;
   logic          c_io;
   logic          c_idone, c_rdone, c_wdone;
   logic [RV-1:0] c_rdata;
   logic          d_req, d_we;
   logic [AW-1:0] d_addr;
   logic [MW-1:0] d_wmask;
   logic [RV-1:0] d_wdata;
   logic          d_ack;
   logic [RV-1:0] d_rdata;
   logic          m_valid, m_we, m_io, m_ready, bus_fault;
   logic [AW-1:0] m_addr;
   logic [MW-1:0] m_wmask;
   logic [1:0]    m_rstrobe;
   logic [RV-1:0] m_wdata, m_rdata;

   // Downstream responder: directed values or random values.
   logic          resp_on;
   logic          dir_ready, rnd_ready;
   logic [RV-1:0] dir_rdata, rnd_rdata;
   assign m_ready = resp_on ? rnd_ready : dir_ready;
   assign m_rdata = resp_on ? rnd_rdata : dir_rdata;

   always @(negedge clk) begin
      rnd_ready = ($urandom_range(0, 9) < 5);
      rnd_rdata = $urandom();
   end

   mem_bus_arbiter #(.RV(RV), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .c_ifetch(c_ifetch), .c_rstrobe(c_rstrobe), .c_wmask(c_wmask),
      .c_addr(c_addr), .c_wdata(c_wdata), .c_io(c_io),
      .c_idone(c_idone), .c_rdone(c_rdone), .c_wdone(c_wdone), .c_rdata(c_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wmask(d_wmask),
      .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
      .m_valid(m_valid), .m_we(m_we), .m_addr(m_addr), .m_wmask(m_wmask),
      .m_rstrobe(m_rstrobe), .m_wdata(m_wdata), .m_io(m_io),
      .m_ready(m_ready), .m_rdata(m_rdata), .bus_fault(bus_fault)
   );

   // ---------------- scoreboard counters ----------------
   int n_checks = 0;
   int n_pass   = 0;
   bit cmp_on   = 1'b0;

   function automatic void check(input string name, input logic [63:0] act,
                                 input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endfunction

   // ---------------- reference model ----------------
   // The model tracks who owns the bus and how long the owner has held it.
   // It also tracks whether the completion cycle is being shown.
   // Expected outputs are valid after each rising edge.
   int            own, age, last, kind;
   bit            finishing, dma_wr, cwant;
   logic          e_valid, e_we, e_io, e_idone, e_rdone, e_wdone, e_ack, e_fault;
   logic [AW-1:0] e_addr;
   logic [MW-1:0] e_wmask;
   logic [1:0]    e_rstrobe;
   logic [RV-1:0] e_wdata, e_crdata, e_drdata, word;

   always @(posedge clk) begin
      e_idone = 0; e_rdone = 0; e_wdone = 0; e_ack = 0; e_fault = 0;
      if (!reset) begin
         own = -1; age = 0; last = 1; finishing = 0; kind = K_FETCH; dma_wr = 0;
         e_valid = 0; e_we = 0; e_io = 0; e_wmask = '0; e_rstrobe = 2'b00;
         e_addr = '0; e_wdata = '0; e_crdata = '0; e_drdata = '0;
      end else if (finishing) begin
         last = own;
         own = -1;
         finishing = 0;
      end else if (own >= 0) begin
         if (m_ready || age == TIMEOUT - 1) begin
            word      = m_ready ? m_rdata : {RV{1'b1}};
            e_fault   = !m_ready;
            e_valid   = 0;
            finishing = 1;
            if (kind == K_DMA) begin
               e_ack = 1;
               if (!dma_wr) e_drdata = word;
            end else if (kind == K_WRITE) e_wdone = 1;
            else begin
               if (kind == K_READ) e_rdone = 1; else e_idone = 1;
               e_crdata = word;
            end
         end else age++;
      end else begin
         cwant = c_ifetch || (c_rstrobe != 2'b00) || (c_wmask != '0);
         if (cwant && d_req) own = (last == 1) ? 0 : 1;
         else if (cwant)     own = 0;
         else if (d_req)     own = 1;
         if (own >= 0) begin
            age = 0;
            e_valid = 1;
            if (own == 1) begin
               kind = K_DMA; dma_wr = d_we;
               e_addr = d_addr; e_wdata = d_wdata; e_we = d_we; e_io = 0;
               e_wmask = d_we ? d_wmask : '0;
               e_rstrobe = d_we ? 2'b00 : 2'b11;
            end else begin
               e_addr = c_addr; e_wdata = c_wdata;
               if (c_wmask != '0) begin
                  kind = K_WRITE; e_we = 1; e_wmask = c_wmask; e_rstrobe = 2'b00; e_io = c_io;
               end else if (c_rstrobe != 2'b00) begin
                  kind = K_READ; e_we = 0; e_wmask = '0; e_rstrobe = c_rstrobe; e_io = c_io;
               end else begin
                  kind = K_FETCH; e_we = 0; e_wmask = '0; e_rstrobe = 2'b11; e_io = 0;
               end
            end
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (cmp_on) begin
         check("m_valid",   m_valid,   e_valid);
         check("c_idone",   c_idone,   e_idone);
         check("c_rdone",   c_rdone,   e_rdone);
         check("c_wdone",   c_wdone,   e_wdone);
         check("d_ack",     d_ack,     e_ack);
         check("bus_fault", bus_fault, e_fault);
         check("c_rdata",   c_rdata,   e_crdata);
         check("d_rdata",   d_rdata,   e_drdata);
         if (e_valid) begin
            check("m_we",      m_we,      e_we);
            check("m_addr",    m_addr,    e_addr);
            check("m_wmask",   m_wmask,   e_wmask);
            check("m_rstrobe", m_rstrobe, e_rstrobe);
            check("m_wdata",   m_wdata,   e_wdata);
            check("m_io",      m_io,      e_io);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic core_random();
      int k;
      bit seen;
      k = $urandom_range(0, 2);
      c_addr  = AW'($urandom());
      c_wdata = $urandom();
      c_io    = 1'($urandom_range(0, 1));
      case (k)
         0:       c_ifetch  = 1'b1;
         1:       c_rstrobe = 2'($urandom_range(1, 3));
         default: c_wmask   = MW'($urandom_range(1, 15));
      endcase
      seen = 0;
      for (int n = 0; n < 40 && !seen; n++) begin
         @(negedge clk);
         if (c_idone || c_rdone || c_wdone) seen = 1;
         else begin
            // Address and data wander while waiting.  Only the values present at grant may matter.
            c_addr  = AW'($urandom());
            c_wdata = $urandom();
         end
      end
      check("core_done_wait", seen, 1'b1);
      c_ifetch = 0; c_rstrobe = 2'b00; c_wmask = '0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
   endtask

   task automatic dma_random();
      bit seen;
      d_we    = 1'($urandom_range(0, 1));
      d_addr  = AW'($urandom());
      d_wdata = $urandom();
      d_wmask = MW'($urandom_range(0, 15));
      d_req   = 1'b1;
      seen = 0;
      for (int n = 0; n < 40 && !seen; n++) begin
         @(negedge clk);
         if (d_ack) seen = 1;
      end
      check("dma_ack_wait", seen, 1'b1);
      d_req = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int nv;
      bit seen;
      int order[$];

      reset = 0; resp_on = 0; dir_ready = 0; dir_rdata = '0;
      c_ifetch = 0; c_rstrobe = 2'b00; c_wmask = '0; c_addr = '0; c_wdata = '0; c_io = 0;
      d_req = 0; d_we = 0; d_addr = '0; d_wmask = '0; d_wdata = '0;
      repeat (2) @(negedge clk);
      cmp_on = 1'b1;

      // Reset state
      check("rst_m_valid", m_valid, 1'b0);
      check("rst_d_ack", d_ack, 1'b0);
      check("rst_c_rdata", c_rdata, 32'h0);
      check("rst_m_addr", m_addr, 30'h0);
      reset = 1;
      @(negedge clk);

      // Core fetch. m_ready comes 2 cycles after m_valid.
      c_addr = 30'h10; c_ifetch = 1;
      @(negedge clk);
      check("fetch_valid", m_valid, 1'b1);
      check("fetch_rstrobe", m_rstrobe, 2'b11);
      check("fetch_addr", m_addr, 30'h10);
      @(negedge clk);
      check("fetch_valid_hold", m_valid, 1'b1);
      dir_ready = 1; dir_rdata = 32'h12345678;
      @(negedge clk);
      dir_ready = 0;
      check("fetch_idone", c_idone, 1'b1);
      check("fetch_rdata", c_rdata, 32'h12345678);
      @(negedge clk);
      check("fetch_idone_once", c_idone, 1'b0);
      check("fetch_no_reissue", m_valid, 1'b0);
      c_ifetch = 0;
      @(negedge clk);

      // Core byte write to IO space
      c_wmask = 4'b0100; c_wdata = 32'hAAAAAAAA; c_io = 1; c_addr = 30'h20;
      @(negedge clk);
      check("wr_we", m_we, 1'b1);
      check("wr_wmask", m_wmask, 4'b0100);
      check("wr_io", m_io, 1'b1);
      check("wr_wdata", m_wdata, 32'hAAAAAAAA);
      dir_ready = 1; dir_rdata = 32'h55550000;
      @(negedge clk);
      dir_ready = 0;
      check("wr_wdone", c_wdone, 1'b1);
      check("wr_no_idone", c_idone, 1'b0);
      check("wr_no_rdone", c_rdone, 1'b0);
      check("wr_rdata_held", c_rdata, 32'h12345678);
      c_wmask = '0; c_io = 0; c_wdata = '0;
      @(negedge clk);

      // DMA read with no m_ready. The watchdog aborts it.
      d_req = 1; d_we = 0; d_addr = 30'h40;
      nv = 0; seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (d_ack) seen = 1;
         else if (m_valid) nv++;
      end
      check("to_ack_seen", seen, 1'b1);
      check("to_valid_cycles", nv, 4);
      check("to_fault", bus_fault, 1'b1);
      check("to_rdata", d_rdata, 32'hFFFFFFFF);
      d_req = 0;
      @(negedge clk);
      // The next request proceeds normally.
      d_req = 1; d_we = 1; d_wmask = 4'b0011; d_wdata = 32'h0BADBEEF; dir_ready = 1;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (d_ack) seen = 1;
      end
      check("after_to_ack", seen, 1'b1);
      check("after_to_fault", bus_fault, 1'b0);
      check("after_to_rdata_held", d_rdata, 32'hFFFFFFFF);
      d_req = 0; dir_ready = 0; d_we = 0;
      @(negedge clk);

      // Reset during BUSY of a core read
      c_rstrobe = 2'b10; c_addr = 30'h80;
      @(negedge clk);
      check("rb_valid", m_valid, 1'b1);
      check("rb_rstrobe", m_rstrobe, 2'b10);
      reset = 0;
      @(negedge clk);
      check("rb_abandon_valid", m_valid, 1'b0);
      check("rb_no_rdone", c_rdone, 1'b0);
      reset = 1;
      @(negedge clk);
      check("rb_reissue", m_valid, 1'b1);
      dir_ready = 1; dir_rdata = 32'hCAFEF00D;
      @(negedge clk);
      dir_ready = 0;
      check("rb_rdone", c_rdone, 1'b1);
      check("rb_rdata", c_rdata, 32'hCAFEF00D);
      c_rstrobe = 2'b00;
      @(negedge clk);

      // Tie from reset. The core wins first, then the masters alternate.
      reset = 0;
      repeat (2) @(negedge clk);
      reset = 1; c_rstrobe = 2'b01; d_req = 1; d_we = 0; dir_ready = 1; dir_rdata = 32'h01020304;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (c_rdone) order.push_back(0);
         if (d_ack)   order.push_back(1);
      end
      check("tie_count", order.size() >= 4, 1'b1);
      if (order.size() >= 4)
         for (int i = 0; i < 4; i++) check("tie_order", order[i], i % 2);
      c_rstrobe = 2'b00; d_req = 0;
      repeat (4) @(negedge clk);
      dir_ready = 0;
      @(negedge clk);

      // Randomized phase
      resp_on = 1;
      fork
         begin
            for (int i = 0; i < 60; i++) core_random();
         end
         begin
            for (int i = 0; i < 60; i++) dma_random();
         end
      join
      resp_on = 0;
      repeat (4) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Global time bound
   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not complete, %0d/%0d", n_pass, n_checks);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single downstream memory/IO port between two masters: the execute unit (master 0, level-held fetch/read/write requests completed by done pulses) and a DMA/debug master (master 1, req/ack handshake).
- Sequences each transaction through IDLE/BUSY/DONE and arbitrates round-robin when both masters are pending.
- Enforces a bus watchdog that aborts stalled transactions.

Parameters:
- RV, 32, data width (16 or 32)
- VA, RV, virtual address width
- AW, VA-RV/16, address width, halfword/word granule
- TIMEOUT, 255, max BUSY cycles before abort (1..255, 8-bit counter)

Ports:
- clk  in  1  clock
- reset  in  1  reset: synchronous, active-low; clock clk
- c_ifetch  in  1  core instruction fetch request (level)
- c_rstrobe  in  2  core data read strobes {hi,lo} (level)
- c_wmask  in  RV/8  core write byte mask; nonzero = write request (level)
- c_addr  in  AW  core address
- c_wdata  in  RV  core write data
- c_io  in  1  core IO-space access
- c_idone  out  1  fetch complete pulse
- c_rdone  out  1  read complete pulse
- c_wdone  out  1  write complete pulse
- c_rdata  out  RV  read/fetch data, valid with c_idone/c_rdone
- d_req  in  1  DMA request (level until d_ack)
- d_we  in  1  DMA write
- d_addr  in  AW  DMA address
- d_wmask  in  RV/8  DMA write mask
- d_wdata  in  RV  DMA write data
- d_ack  out  1  DMA complete pulse
- d_rdata  out  RV  DMA read data, valid with d_ack
- m_valid  out  1  downstream request
- m_we  out  1  downstream write
- m_addr  out  AW  downstream address
- m_wmask  out  RV/8  downstream write mask
- m_rstrobe  out  2  downstream read lane strobes
- m_wdata  out  RV  downstream write data
- m_io  out  1  downstream IO access
- m_ready  in  1  downstream completion; m_rdata valid same cycle
- m_rdata  in  RV  downstream read data
- bus_fault  out  1  watchdog abort pulse

Behaviour:
- Core request: creq = c_ifetch | (|c_rstrobe) | (|c_wmask). Core priority within master 0: write > read > fetch (mutually exclusive in normal operation).
- State machine (all outputs registered):
  - IDLE: no request -> stay. One master requesting -> grant it. Both requesting -> grant the master not in last_grant. Latch master signals into m_* regs, go BUSY. m_valid=1 from the next cycle.
  - Core read: m_rstrobe=c_rstrobe, m_we=0. Core fetch: m_rstrobe=2'b11, m_io=0. Core write: m_wmask=c_wmask, m_we=1, m_rstrobe=0. m_io=c_io for core data.
  - DMA: m_we=d_we; write uses d_wmask; read uses m_rstrobe=2'b11; m_io=0.
  - BUSY: m_* held stable. Cycle counter increments each cycle.
  - BUSY, m_ready=1: m_valid<=0, capture m_rdata, go DONE.
  - BUSY, counter==TIMEOUT-1 with no m_ready: same as completion, but captured data = all ones and bus_fault pulses 1 cycle with the done pulse.
  - DONE: exactly one done pulse to the granted master, for its type (c_idone, c_rdone, c_wdone, or d_ack). Read data presented on c_rdata/d_rdata and held until the next done. last_grant updated. Next state IDLE.
  - Requests are never sampled in DONE. This prevents re-issuing a request the master is still holding during its done cycle.
- Latency: request seen in IDLE at cycle N -> m_valid at N+1. m_ready at cycle K -> done pulse at K+1. Minimum 3 cycles per transaction (m_ready at N+1 gives done at N+2).
- m_ready outside BUSY is ignored.
- Core request changing mid-BUSY is ignored; the transaction completes with latched values.
- Reset low (any state):
  - next state IDLE; last_grant = DMA, so the core wins the first tie.
  - counter 0; m_valid, m_we, m_wmask, m_rstrobe, m_io = 0.
  - all done pulses, d_ack and bus_fault = 0; c_rdata, d_rdata, m_addr, m_wdata = 0.
  - An in-flight downstream transaction is abandoned without a done pulse.

Test Plan:
- Core fetch c_addr=0x10, m_ready 2 cycles after m_valid, m_rdata=0x12345678 -> c_idone exactly 1 cycle with c_rdata=0x12345678; m_rstrobe=2'b11; no second m_valid while c_ifetch still high in DONE.
- Core byte write c_wmask=4'b0100, c_wdata=0xAAAAAAAA, c_io=1 -> m_we=1, m_wmask=4'b0100, m_io=1; c_wdone 1 cycle after m_ready; c_idone/c_rdone stay 0.
- d_req and c_rstrobe=2'b01 asserted together from reset, both held -> core served first, then DMA, then core; d_ack and c_rdone alternate.
- DMA read, m_ready never asserted, TIMEOUT=4 -> m_valid high 4 cycles, then d_ack=1, bus_fault=1, d_rdata=0xFFFFFFFF; next request proceeds normally.
- Reset low during BUSY of a core read -> next cycle m_valid=0, c_rdone never pulses, state IDLE; after release, the still-held read reissues with m_valid 1 cycle later.
- RV=16 build: core write c_wmask=2'b10 -> m_wmask=2'b10; AW=VA-1; DMA read returns 16-bit d_rdata.
